// File: rtl/fetch_stage_bp.sv
`timescale 1ns/1ps
// Fetch stage with BTB and 2-bit direction predictor; owns the PC and drives the sync imem address.
// Address to instruction is 1 cycle, predicted-taken adds no bubble; stall holds the PC, and redirects override stall.
module fetch_stage_bp #(
   parameter int                ADDR_W    = 32,
   parameter int                INSTR_W   = 32,
   parameter int                BTB_DEPTH = 16,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(1),
   parameter int                CNT_W     = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               stall,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_q,
   output logic [INSTR_W-1:0] instruction,
   output logic [ADDR_W-1:0]  fetch_pc,
   output logic               fetch_valid,
   output logic               prediction,
   output logic [ADDR_W-1:0]  pred_target,
   input  logic               jr,
   input  logic [ADDR_W-1:0]  jr_addr,
   input  logic               res_valid,
   input  logic [ADDR_W-1:0]  res_pc,
   input  logic               res_taken,
   input  logic [ADDR_W-1:0]  res_target,
   input  logic               res_mispredict,
   input  logic [ADDR_W-1:0]  res_correct_pc,
   output logic               if_flush,
   output logic [CNT_W-1:0]   mispredict_count
);

   localparam int IDX_W = (BTB_DEPTH > 1) ? $clog2(BTB_DEPTH) : 1;
   localparam int TAG_W = ADDR_W - IDX_W;

   typedef struct packed {
      logic              vld;
      logic [TAG_W-1:0]  tag;
      logic [ADDR_W-1:0] target;
      logic [1:0]        cnt;
   } btb_entry_t;

   btb_entry_t        btb_mem [BTB_DEPTH];
   logic              started;
   logic [ADDR_W-1:0] pc_q;
   logic [CNT_W-1:0]  mp_cnt;
   logic [IDX_W-1:0]  lk_idx;
   logic [IDX_W-1:0]  up_idx;
   btb_entry_t        lk_ent;
   btb_entry_t        up_ent;
   logic              lk_hit;
   logic              up_hit;
   logic              mp_redirect;
   logic [ADDR_W-1:0] next_pc;

   // Lookup reads the array as it stood before this cycle's update edge.
   assign lk_idx      = pc_q[IDX_W-1:0];
   assign lk_ent      = btb_mem[lk_idx];
   assign lk_hit      = lk_ent.vld && (lk_ent.tag == pc_q[ADDR_W-1:IDX_W]);
   assign prediction  = lk_hit & lk_ent.cnt[1];
   assign pred_target = lk_hit ? lk_ent.target : '0;

   assign up_idx = res_pc[IDX_W-1:0];
   assign up_ent = btb_mem[up_idx];
   assign up_hit = up_ent.vld && (up_ent.tag == res_pc[ADDR_W-1:IDX_W]);

   assign mp_redirect = res_valid & res_mispredict;

   always_comb begin
      next_pc = pc_q + PC_STEP;
      if (!started)
         next_pc = RESET_PC;
      else if (mp_redirect)
         next_pc = res_correct_pc;
      else if (jr)
         next_pc = jr_addr;
      else if (stall)
         next_pc = pc_q;
      else if (prediction)
         next_pc = pred_target;
   end

   assign imem_addr        = next_pc;
   assign instruction      = imem_q;
   assign fetch_pc         = pc_q;
   assign if_flush         = started & (mp_redirect | jr);
   assign fetch_valid      = started & ~if_flush & ~stall;
   assign mispredict_count = mp_cnt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         started <= 1'b0;
         pc_q    <= RESET_PC;
         mp_cnt  <= '0;
      end else begin
         started <= 1'b1;
         pc_q    <= next_pc;
         if (mp_redirect && (mp_cnt != '1))
            mp_cnt <= mp_cnt + CNT_W'(1);
      end
   end

   // Training is independent of whether the branch also caused a redirect.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < BTB_DEPTH; i++)
            btb_mem[i] <= '{vld: 1'b0, tag: '0, target: '0, cnt: 2'b01};
      end else if (res_valid) begin
         if (up_hit) begin
            if (res_taken) begin
               btb_mem[up_idx].cnt    <= (up_ent.cnt == 2'b11) ? 2'b11 : up_ent.cnt + 2'd1;
               btb_mem[up_idx].target <= res_target;
            end else begin
               btb_mem[up_idx].cnt    <= (up_ent.cnt == 2'b00) ? 2'b00 : up_ent.cnt - 2'd1;
            end
         end else if (res_taken) begin
            btb_mem[up_idx] <= '{vld: 1'b1, tag: res_pc[ADDR_W-1:IDX_W],
                                 target: res_target, cnt: 2'b10};
         end
      end
   end

endmodule
